// File: rtl/conv_out_pkg.sv
// Shared defaults and the output-buffer address helper for the conv output writer.
package conv_out_pkg;

    localparam int unsigned CONV_DATA_W             = 256;
    localparam int unsigned CONV_ADDR_W             = 16;
    localparam int unsigned CONV_FIFO_DEPTH         = 4;
    localparam int unsigned CONV_PIXELS_IN_ROW_LOG2 = 5;

    // Word address of an output row; all terms kept at 32 bits, caller truncates.
    function automatic logic [31:0] out_word_addr(
        input logic [31:0] base,
        input logic [15:0] y_idx,
        input logic [15:0] x_idx,
        input logic [15:0] f_idx,
        input logic [15:0] of_s,
        input logic [15:0] ox_s,
        input int unsigned pix_log2
    );
        logic [31:0] s;
        logic [31:0] y_term;
        logic [31:0] x_term;
        s = {16'd0, of_s} + {16'd0, ox_s};
        if (s >= pix_log2) begin
            y_term = {16'd0, y_idx} << (s - pix_log2);
        end else begin
            y_term = {16'd0, y_idx} >> (pix_log2 - s);
        end
        x_term = ({16'd0, x_idx} << of_s) >> pix_log2;
        return base + y_term + x_term + {16'd0, f_idx};
    endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// First-word fall-through write queue; the MSB of each entry is a flag that can be
// set on the youngest entry after it was queued.
module conv_out_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     mark_tail,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
        if (mark_tail && !empty) begin
            mem[wptr - PTR_W'(1)][WIDTH-1] <= 1'b1;
        end
    end

endmodule

// File: rtl/conv_out_buf_writer.sv
// Output-row writer: computes the buffer address for each quantised row, queues it and
// streams writes to the output buffer, reporting tile completion and row loss.
module conv_out_buf_writer
    import conv_out_pkg::*;
#(
    parameter int unsigned DATA_W             = CONV_DATA_W,
    parameter int unsigned ADDR_W             = CONV_ADDR_W,
    parameter int unsigned FIFO_DEPTH         = CONV_FIFO_DEPTH,
    parameter int unsigned PIXELS_IN_ROW_LOG2 = CONV_PIXELS_IN_ROW_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [15:0]       in_y_idx,
    input  logic [15:0]       in_x_idx,
    input  logic [15:0]       in_f_idx,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [15:0]       of_in_2pow,
    input  logic [15:0]       ox_in_2pow,
    input  logic [ADDR_W-1:0] buf_base,
    input  logic              buf_ready,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic              in_almost_full,
    output logic              busy,
    output logic              tile_done,
    output logic              overflow_err
);
    localparam int unsigned ENT_W = DATA_W + ADDR_W + 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              s1_valid;
    logic              s1_last;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_data;
    logic [31:0]       row_addr;

    logic [ENT_W-1:0]  head;
    logic              head_last;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    logic              orphan_last;
    logic              drained;
    logic              mark_tail;
    logic              tile_done_q;
    logic              overflow_q;

    assign row_addr = out_word_addr(32'(buf_base), in_y_idx, in_x_idx, in_f_idx,
                                    of_in_2pow, ox_in_2pow, PIXELS_IN_ROW_LOG2);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_addr  <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_last  <= in_last;
            s1_addr  <= row_addr[ADDR_W-1:0];
            s1_data  <= in_data;
        end
    end

    conv_out_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s1_valid),
        .push_data ({s1_last, s1_addr, s1_data}),
        .pop       (buf_we),
        .mark_tail (mark_tail),
        .head_data (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign {head_last, head_addr, head_data} = head;

    assign buf_we    = !empty && buf_ready;
    assign buf_addr  = buf_we ? head_addr : '0;
    assign buf_wdata = buf_we ? head_data : '0;

    // A late end-of-tile pulse rides on the youngest queued row, unless that row is
    // leaving this cycle (or nothing is queued), in which case the tile is done now.
    assign orphan_last = s1_last && !s1_valid;
    assign drained     = empty || ((count == CNT_W'(1)) && buf_we);
    assign mark_tail   = orphan_last && !drained;

    assign in_almost_full = (32'(count) + 32'(s1_valid)) >= (FIFO_DEPTH - 1);
    assign busy           = s1_valid || !empty;
    assign tile_done      = tile_done_q;
    assign overflow_err   = overflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tile_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            tile_done_q <= (buf_we && head_last) || (orphan_last && drained);
            if (s1_valid && full && !buf_we) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_out_buf_writer.sv
// Randomised bench for conv_out_buf_writer against a queue-based transaction model.
module tb_conv_out_buf_writer;

    localparam int unsigned DATA_W = 256;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PIXL2  = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [15:0]       in_y_idx = '0;
    logic [15:0]       in_x_idx = '0;
    logic [15:0]       in_f_idx = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic [15:0]       of_in_2pow = '0;
    logic [15:0]       ox_in_2pow = '0;
    logic [ADDR_W-1:0] buf_base = '0;
    logic              buf_ready = 1'b0;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_wdata;
    logic              in_almost_full;
    logic              busy;
    logic              tile_done;
    logic              overflow_err;

    conv_out_buf_writer dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_y_idx       (in_y_idx),
        .in_x_idx       (in_x_idx),
        .in_f_idx       (in_f_idx),
        .in_data        (in_data),
        .in_last        (in_last),
        .of_in_2pow     (of_in_2pow),
        .ox_in_2pow     (ox_in_2pow),
        .buf_base       (buf_base),
        .buf_ready      (buf_ready),
        .buf_we         (buf_we),
        .buf_addr       (buf_addr),
        .buf_wdata      (buf_wdata),
        .in_almost_full (in_almost_full),
        .busy           (busy),
        .tile_done      (tile_done),
        .overflow_err   (overflow_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        bit                last;
    } ent_t;

    ent_t mq[$];
    ent_t ms1;
    bit   ms1_valid = 0;
    bit   ms1_last  = 0;
    bit   m_done    = 0;
    bit   m_ovf     = 0;
    bit   chk_en    = 0;
    int   wr_cnt    = 0;
    int   done_cnt  = 0;
    bit   af_seen   = 0;

    // Address from the stride rules using plain arithmetic (powers of two as products).
    function automatic logic [ADDR_W-1:0] model_addr(input longint base, input longint y,
                                                     input longint x, input longint f,
                                                     input longint ofs, input longint oxs);
        longint s;
        longint yt;
        longint xt;
        s = ofs + oxs;
        if (s >= PIXL2) yt = y * (longint'(2) ** (s - PIXL2));
        else            yt = y / (longint'(2) ** (PIXL2 - s));
        xt = (x * (longint'(2) ** ofs)) / (longint'(2) ** PIXL2);
        return ADDR_W'((base + yt + xt + f) % (longint'(2) ** ADDR_W));
    endfunction

    always @(negedge clk) begin : model
        ent_t e;
        bit   exp_we;
        bit   pop;
        bit   drained;
        bit   orphan;
        bit   nd;
        exp_we = (mq.size() > 0) && buf_ready;
        if (chk_en) begin
            check_eq("buf_we", buf_we, exp_we);
            if (exp_we) begin
                check_eq("buf_addr", buf_addr, mq[0].addr);
                check_eq("buf_wdata", buf_wdata, mq[0].data);
            end else begin
                check_eq("buf_addr_idle", buf_addr, 0);
                check_eq("buf_wdata_idle", buf_wdata, 0);
            end
            check_eq("almost_full", in_almost_full, (mq.size() + ms1_valid) >= DEPTH - 1);
            check_eq("busy", busy, ms1_valid || (mq.size() > 0));
            check_eq("tile_done", tile_done, m_done);
            check_eq("overflow_err", overflow_err, m_ovf);
        end
        if (buf_we === 1'b1) wr_cnt++;
        if (tile_done === 1'b1) done_cnt++;
        if (in_almost_full === 1'b1) af_seen = 1;

        if (reset) begin
            mq.delete();
            ms1_valid = 0;
            ms1_last  = 0;
            m_done    = 0;
            m_ovf     = 0;
        end else begin
            pop     = exp_we;
            orphan  = ms1_last && !ms1_valid;
            drained = (mq.size() == 0) || ((mq.size() == 1) && pop);
            nd      = pop && mq[0].last;
            if (orphan && drained) begin
                nd = 1;
            end else if (orphan) begin
                e = mq[mq.size() - 1];
                e.last = 1;
                mq[mq.size() - 1] = e;
            end
            if (pop) void'(mq.pop_front());
            if (ms1_valid) begin
                if (mq.size() < DEPTH) mq.push_back(ms1);
                else                   m_ovf = 1;
            end
            m_done    = nd;
            ms1_valid = in_valid;
            ms1_last  = in_last;
            ms1.addr  = model_addr(buf_base, in_y_idx, in_x_idx, in_f_idx,
                                   of_in_2pow, ox_in_2pow);
            ms1.data  = in_data;
            ms1.last  = in_last;
        end
    end

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive(input bit v, input bit l, input logic [15:0] y,
                         input logic [15:0] x, input logic [15:0] f);
        @(posedge clk);
        #1;
        in_valid = v;
        in_last  = l;
        in_y_idx = y;
        in_x_idx = x;
        in_f_idx = f;
        in_data  = rand_data();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_en = 1;
        settle();
        check_eq("rst_buf_we", buf_we, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_almost_full", in_almost_full, 0);
        check_eq("rst_overflow", overflow_err, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single row, large stride: address 40, written two cycles after in_valid.
        buf_ready  = 1;
        of_in_2pow = 4;
        ox_in_2pow = 5;
        buf_base   = 0;
        drive(1, 0, 2, 3, 7);
        drive(0, 0, 0, 0, 0);
        settle();
        check_eq("lat_not_early", buf_we, 0);
        settle();
        check_eq("lat_we", buf_we, 1);
        check_eq("addr_40", buf_addr, 40);
        idle(3);

        // S below the pixel log2: y term shifts right.
        of_in_2pow = 2;
        ox_in_2pow = 1;
        buf_base   = 100;
        drive(1, 0, 8, 0, 0);
        drive(0, 0, 0, 0, 0);
        settle();
        settle();
        check_eq("addr_102", buf_addr, 102);
        idle(3);

        // 16 back-to-back rows at full rate.
        of_in_2pow = 3;
        ox_in_2pow = 4;
        wr_cnt  = 0;
        af_seen = 0;
        for (int i = 0; i < 16; i++) drive(1, 0, 16'(i), 16'(i * 3), 16'(i));
        idle(5);
        check_eq("b2b_writes", 32'(wr_cnt), 16);
        check_eq("b2b_no_af", af_seen, 0);

        // Stall with 3 rows: almost-full, then drain.
        buf_ready = 0;
        wr_cnt    = 0;
        for (int i = 0; i < 3; i++) drive(1, 0, 16'(i), 1, 2);
        drive(0, 0, 0, 0, 0);
        settle();
        check_eq("af_after_3", in_almost_full, 1);
        @(posedge clk);
        #1 buf_ready = 1;
        idle(6);
        check_eq("drain_3_writes", 32'(wr_cnt), 3);
        check_eq("af_dropped", in_almost_full, 0);

        // Stall with 5 rows: one lost, sticky error, 4 writes.
        buf_ready = 0;
        wr_cnt    = 0;
        for (int i = 0; i < 5; i++) drive(1, 0, 16'(i + 9), 5, 1);
        idle(3);
        check_eq("ovf_set", overflow_err, 1);
        @(posedge clk);
        #1 buf_ready = 1;
        idle(8);
        check_eq("ovf_4_writes", 32'(wr_cnt), 4);
        check_eq("ovf_sticky", overflow_err, 1);

        // Tile with last on the final row, then reset mid-queue on a second tile.
        do_reset();
        done_cnt = 0;
        for (int i = 0; i < 4; i++) drive(1, i == 3, 16'(i), 16'(i), 0);
        idle(6);
        check_eq("tile_done_once", 32'(done_cnt), 1);
        buf_ready = 0;
        for (int i = 0; i < 3; i++) drive(1, 0, 16'(i), 0, 3);
        @(posedge clk);
        #1;
        in_valid  = 0;
        reset     = 1;
        buf_ready = 1;
        @(posedge clk);
        #1;
        reset  = 0;
        wr_cnt = 0;
        idle(8);
        check_eq("no_write_after_reset", 32'(wr_cnt), 0);
        check_eq("idle_after_reset", busy, 0);

        // Late end-of-tile pulse: with rows queued and with nothing in flight.
        done_cnt  = 0;
        buf_ready = 0;
        drive(1, 0, 1, 1, 1);
        drive(1, 0, 2, 2, 2);
        drive(0, 1, 0, 0, 0);
        idle(2);
        buf_ready = 1;
        idle(5);
        drive(0, 1, 0, 0, 0);
        idle(4);
        check_eq("late_last_done", 32'(done_cnt), 2);

        // Randomised traffic, upstream honouring the model's almost-full.
        for (int blk = 0; blk < 6; blk++) begin
            of_in_2pow = 16'($urandom_range(0, 6));
            ox_in_2pow = 16'($urandom_range(0, 8));
            buf_base   = 16'($urandom);
            for (int i = 0; i < 60; i++) begin
                bit v;
                v = ($urandom_range(0, 3) != 0) && ((mq.size() + ms1_valid) < DEPTH - 1);
                buf_ready = ($urandom_range(0, 3) != 0);
                drive(v, $urandom_range(0, 9) == 0, 16'($urandom), 16'($urandom),
                      16'($urandom));
            end
            buf_ready = 1;
            idle(6);
        end
        check_eq("rand_no_ovf", overflow_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
